// File: rtl/cpu_defs.sv
// Shared MULT/DIV definitions: op encodings and sequencer state codes.
// Also used by the control unit stall logic to decode the sequencer state.
package cpu_defs;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam logic [2:0] MD_IDLE = 3'd0;
    localparam logic [2:0] MD_LOAD = 3'd1;
    localparam logic [2:0] MD_ITER = 3'd2;
    localparam logic [2:0] MD_FIX  = 3'd3;
    localparam logic [2:0] MD_DONE = 3'd4;

endpackage

// File: rtl/mult_div_ctrl_md_step.sv
// md_step: one combinational shift-add multiply or restoring divide iteration.
// Ports: i_acc_hi/i_acc_lo accumulator in, i_operand mcand/divisor, i_op, o_acc_hi/o_acc_lo out.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_operand,
    input  logic             i_op,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);
    import cpu_defs::*;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_mhi;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    always_comb begin
        // Multiply: conditional add keeps the carry, then the whole
        // {carry, acc_hi, acc_lo} shifts right by one.
        w_sum = {1'b0, i_acc_hi} + {1'b0, i_operand};
        w_mhi = i_acc_lo[0] ? w_sum : {1'b0, i_acc_hi};
        // Divide: shift next dividend bit into the partial remainder.
        // The true difference is < 2^WIDTH whenever it is used, so a
        // WIDTH-bit subtract is exact.
        w_rem  = {i_acc_hi, i_acc_lo[WIDTH-1]};
        w_ge   = (w_rem >= {1'b0, i_operand});
        w_diff = w_rem[WIDTH-1:0] - i_operand;

        if (i_op == MD_OP_DIV) begin
            o_acc_hi = w_ge ? w_diff : w_rem[WIDTH-1:0];
            o_acc_lo = {i_acc_lo[WIDTH-2:0], w_ge};
        end else begin
            o_acc_hi = w_mhi[WIDTH:1];
            o_acc_lo = {w_mhi[0], i_acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative signed MULT/DIV sequencer writing HI/LO.
// Ports: clk, reset (sync, high), start/op/op_a/op_b request; busy, done,
//        hilo_write, div_zero status pulses; hi/lo result registers.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             hilo_write,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import cpu_defs::*;

    localparam int CW = $clog2(WIDTH);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_b_zero;

    assign w_a_mag  = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_b_mag  = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_b_zero = (r_b == '0);
    assign w_prod   = {r_acc_hi, r_acc_lo};

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_acc_hi  (r_acc_hi),
        .i_acc_lo  (r_acc_lo),
        .i_operand (r_opnd),
        .i_op      (r_op),
        .o_acc_hi  (w_step_hi),
        .o_acc_lo  (w_step_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (start) w_state_nxt = MD_LOAD;
            MD_LOAD: begin
                if (r_op == MD_OP_DIV && w_b_zero) w_state_nxt = MD_DONE;
                else                               w_state_nxt = MD_ITER;
            end
            MD_ITER: if (r_cnt == '0) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_DONE;
            MD_DONE: w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != MD_IDLE);
        done       = (r_state == MD_DONE);
        hilo_write = (r_state == MD_DONE) && !r_dz;
        div_zero   = (r_state == MD_DONE) && r_dz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= MD_OP_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= op_a;
                        r_b  <= op_b;
                    end
                end
                MD_LOAD: begin
                    r_acc_hi  <= '0;
                    r_acc_lo  <= w_a_mag;
                    r_opnd    <= w_b_mag;
                    r_neg_res <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_neg_rem <= r_a[WIDTH-1];
                    r_dz      <= (r_op == MD_OP_DIV) && w_b_zero;
                    r_cnt     <= CW'(WIDTH-1);
                end
                MD_ITER: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt - CW'(1);
                end
                MD_FIX: begin
                    if (r_op == MD_OP_DIV) begin
                        r_lo <= r_neg_res ? -r_acc_lo : r_acc_lo;
                        r_hi <= r_neg_rem ? -r_acc_hi : r_acc_hi;
                    end else begin
                        {r_hi, r_lo} <= r_neg_res ? -w_prod : w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
